// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the fabric-side word interface of the SPI target.
interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             SCK;
  logic             SSEL;
  logic             MOSI;
  logic             MISO;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

  modport slave (
    input  SCK, SSEL, MOSI, tx_data,
    output MISO, rx_data, rx_valid, busy
  );

  modport master (
    output SCK, SSEL, MOSI, tx_data,
    input  MISO, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-3 target clocked entirely by clk; SCK/SSEL/MOSI are oversampled
// through synchronisers and their edges are detected in the clk domain.
module spi_slave #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  spi_slave_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [2:0]       sck_sync_q, sck_sync_d;
  logic [2:0]       ssel_sync_q, ssel_sync_d;
  logic [1:0]       mosi_sync_q, mosi_sync_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;

  logic             sck_rise, sck_fall, ssel_start, active, mosi_bit;
  logic [WIDTH-1:0] rx_word;

  // Edges are taken from the two oldest stages so stage 0 absorbs metastability.
  assign sck_rise   = ~sck_sync_q[2] &  sck_sync_q[1];
  assign sck_fall   =  sck_sync_q[2] & ~sck_sync_q[1];
  assign ssel_start =  ssel_sync_q[2] & ~ssel_sync_q[1];
  assign active     = ~ssel_sync_q[1];
  assign mosi_bit   =  mosi_sync_q[1];
  assign rx_word    = {rx_shift_q[WIDTH-2:0], mosi_bit};

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], bus.SCK};
    ssel_sync_d = {ssel_sync_q[1:0], bus.SSEL};
    mosi_sync_d = {mosi_sync_q[0], bus.MOSI};
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    busy_d      = active;

    if (ssel_start) begin
      // SCK edges coinciding with frame start are deliberately dropped.
      bit_cnt_d  = '0;
      tx_shift_d = bus.tx_data;
    end else if (active) begin
      if (sck_fall) begin
        miso_d     = tx_shift_q[WIDTH-1];
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end
      if (sck_rise) begin
        rx_shift_d = rx_word;
        if (bit_cnt_q == LAST_BIT) begin
          // Word boundary: publish and reload so words can run back to back.
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
          tx_shift_d = bus.tx_data;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end else begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= 3'b111;
      ssel_sync_q <= 3'b111;
      mosi_sync_q <= 2'b00;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ssel_sync_q <= ssel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-3 initiator drives frames
// and every observation is compared with hand-derived values.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  spi_slave_if #(.WIDTH(8)) bus ();

  spi_slave #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Receive monitor: counts pulses, keeps received words, flags wide pulses.
  int         vcnt = 0;
  int         wide = 0;
  logic       vld_prev = 1'b0;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      vcnt = vcnt + 1;
      rxq.push_back(bus.rx_data);
      if (vld_prev) wide = wide + 1;
    end
    vld_prev = (bus.rx_valid === 1'b1);
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sel();
    bus.SSEL = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic desel();
    repeat (4) @(negedge clk);
    bus.SSEL = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Shifts n bits of mo (MSB first); MISO is sampled late in each high phase.
  // tx_next is applied during the low phase of the last bit.
  task automatic xfer(input logic [7:0] mo, input int half, input int n,
                      input logic [7:0] tx_next, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.SCK  = 1'b0;
      bus.MOSI = mo[7-i];
      if (i == n - 1) bus.tx_data = tx_next;
      repeat (half) @(negedge clk);
      bus.SCK = 1'b1;
      repeat (half - 1) @(negedge clk);
      mi = {mi[6:0], bus.MISO};
      @(negedge clk);
    end
  endtask

  initial begin
    int         v0;
    logic [7:0] mi, mi2, mo, tx;
    int         half;

    bus.SCK = 1'b1; bus.SSEL = 1'b1; bus.MOSI = 1'b0; bus.tx_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk8("reset_miso", {7'd0, bus.MISO}, 8'h00);
    chk8("reset_rx_data", bus.rx_data, 8'h00);
    chk8("reset_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
    chk8("reset_busy", {7'd0, bus.busy}, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame at clk/8
    v0 = vcnt;
    bus.tx_data = 8'hC3;
    sel();
    chk8("single_busy", {7'd0, bus.busy}, 8'h01);
    xfer(8'h3C, 4, 8, 8'hC3, mi);
    desel();
    chk8("single_rx", bus.rx_data, 8'h3C);
    chki("single_vcnt", vcnt - v0, 1);
    chk8("single_miso", mi, 8'hC3);
    chk8("single_busy_end", {7'd0, bus.busy}, 8'h00);

    // Reset in the middle of a frame
    bus.tx_data = 8'hF0;
    sel();
    xfer(8'hFF, 4, 4, 8'hF0, mi);
    chk8("midrst_miso_before", {7'd0, bus.MISO}, 8'h01);
    rst = 1'b1;
    #1;
    chk8("midrst_miso", {7'd0, bus.MISO}, 8'h00);
    chk8("midrst_rx_data", bus.rx_data, 8'h00);
    chk8("midrst_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
    chk8("midrst_busy", {7'd0, bus.busy}, 8'h00);
    @(negedge clk);
    bus.SSEL = 1'b1; bus.SCK = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    v0 = vcnt;
    sel();
    xfer(8'hA5, 4, 8, 8'hF0, mi);
    desel();
    chk8("postrst_rx", bus.rx_data, 8'hA5);
    chki("postrst_vcnt", vcnt - v0, 1);

    // Back-to-back words in one frame
    rxq.delete();
    v0 = vcnt;
    bus.tx_data = 8'h55;
    sel();
    xfer(8'h12, 4, 8, 8'hAA, mi);
    xfer(8'h34, 4, 8, 8'hAA, mi2);
    desel();
    chki("b2b_vcnt", vcnt - v0, 2);
    chk8("b2b_rx0", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h12);
    chk8("b2b_rx1", (rxq.size() > 1) ? rxq[1] : 8'hxx, 8'h34);
    chk8("b2b_miso0", mi, 8'h55);
    chk8("b2b_miso1", mi2, 8'hAA);

    // Abort after 5 bits, then a clean frame
    v0 = vcnt;
    bus.tx_data = 8'h00;
    sel();
    xfer(8'hFF, 4, 5, 8'h00, mi);
    repeat (2) @(negedge clk);
    bus.SSEL = 1'b1;
    repeat (6) @(negedge clk);
    chki("abort_vcnt", vcnt - v0, 0);
    chk8("abort_rx_kept", bus.rx_data, 8'h34);
    sel();
    xfer(8'h01, 4, 8, 8'h00, mi);
    desel();
    chk8("after_abort_rx", bus.rx_data, 8'h01);
    chki("after_abort_vcnt", vcnt - v0, 1);

    // Idle: SCK and MOSI wiggle with SSEL high
    v0 = vcnt;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) bus.SCK = ~bus.SCK;
      bus.MOSI = 1'($urandom);
      @(negedge clk);
      if (i % 8 == 7) begin
        chk8("idle_miso", {7'd0, bus.MISO}, 8'h00);
        chk8("idle_busy", {7'd0, bus.busy}, 8'h00);
      end
    end
    bus.SCK = 1'b1;
    repeat (4) @(negedge clk);
    chki("idle_vcnt", vcnt - v0, 0);

    // Random frames at clk/4 then clk/10
    for (int f = 0; f < 200; f++) begin
      half = (f < 100) ? 2 : 5;
      mo = 8'($urandom);
      tx = 8'($urandom);
      v0 = vcnt;
      bus.tx_data = tx;
      sel();
      xfer(mo, half, 8, tx, mi);
      desel();
      chk8("rand_rx", bus.rx_data, mo);
      chki("rand_vcnt", vcnt - v0, 1);
      chk8("rand_miso", mi, tx);
    end

    chki("pulse_width", wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
